// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port, synchronous-read instruction memory between the CPU
// fetch stage and the program loader/debug port. At most one access is granted
// per cycle. Ties are resolved round-robin, and the loader can hold a bounded
// lock. Each response returns to its owner exactly one cycle after the grant.
module imem_port_arbiter #(
    parameter int IDX_W    = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,

    // CPU fetch port
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,

    // Loader / debug port
    input  logic             l_req,
    input  logic             l_we,
    input  logic             l_lock,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_err,

    // Memory side
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int               CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // last_owner FSM: records which requester received the most recent grant
    typedef enum logic {
        OWNER_FETCH  = 1'b0,
        OWNER_LOADER = 1'b1
    } owner_e;

    owner_e           state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // Response pipeline: describes the transaction granted in the previous cycle
    logic             resp_valid_q, resp_valid_d;
    owner_e           resp_owner_q, resp_owner_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_we_q, resp_we_d;

    logic             f_addr_err;
    logic             l_addr_err;
    logic             resp_data_ok;

    // An address is rejected when it is not word aligned or when it lies beyond the memory depth
    assign f_addr_err = (f_addr[1:0] != 2'b00) || (f_addr[31:IDX_W+2] != '0);
    assign l_addr_err = (l_addr[1:0] != 2'b00) || (l_addr[31:IDX_W+2] != '0);

    // Arbitration, next last_owner and lock counter (the combinational half of the FSM)
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;

        // Grants are suppressed while reset is asserted, so no memory access occurs in a reset cycle.
        if (!rst) begin
            if (f_req && !l_req) begin
                f_gnt = 1'b1;
            end else if (l_req && !f_req) begin
                l_gnt = 1'b1;
            end else if (f_req && l_req) begin
                if (lock_cnt_q == LOCK_MAX_C) begin
                    // The lock budget is used up, so the waiting fetch gets one slot.
                    f_gnt = 1'b1;
                end else if (state_q == OWNER_LOADER && l_lock) begin
                    l_gnt = 1'b1;
                end else if (state_q == OWNER_LOADER) begin
                    f_gnt = 1'b1;
                end else begin
                    l_gnt = 1'b1;
                end
            end
        end

        if (l_gnt) begin
            state_d = OWNER_LOADER;
        end else if (f_gnt) begin
            state_d = OWNER_FETCH;
        end

        // The count saturates at LOCK_MAX. A loader that holds the lock alone therefore still yields once a fetch arrives.
        if (f_gnt || !l_lock) begin
            lock_cnt_d = '0;
        end else if (l_gnt && lock_cnt_q != LOCK_MAX_C) begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
        end
    end

    // last_owner and lock counter registers (the sequential half of the FSM)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OWNER_FETCH;
            lock_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment, so every flop samples pre-edge values.
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Drive the memory from the granted requester; all memory signals stay at zero when idle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en  = !f_addr_err;
            mem_idx = f_addr[IDX_W+1:2];
        end else if (l_gnt) begin
            mem_en    = !l_addr_err;
            mem_we    = l_we;
            mem_idx   = l_addr[IDX_W+1:2];
            mem_wdata = l_wdata;
        end
    end

    // Describe the granted transaction so the response can be routed next cycle
    always_comb begin
        resp_valid_d = f_gnt || l_gnt;
        resp_owner_d = OWNER_FETCH;
        resp_err_d   = 1'b0;
        resp_we_d    = 1'b0;
        if (l_gnt) begin
            resp_owner_d = OWNER_LOADER;
            resp_err_d   = l_addr_err;
            resp_we_d    = l_we;
        end else if (f_gnt) begin
            resp_err_d   = f_addr_err;
        end
    end

    // Response pipeline registers; reset discards any response still pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWNER_FETCH;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // Route the response to its owner. Read data passes through only for a successful read.
    always_comb begin
        resp_data_ok = resp_valid_q && !resp_err_q && !resp_we_q;

        f_rvalid = resp_valid_q && (resp_owner_q == OWNER_FETCH);
        f_err    = f_rvalid && resp_err_q;
        f_rdata  = (f_rvalid && resp_data_ok) ? mem_rdata : '0;

        l_rvalid = resp_valid_q && (resp_owner_q == OWNER_LOADER);
        l_err    = l_rvalid && resp_err_q;
        l_rdata  = (l_rvalid && resp_data_ok) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter. It includes a behavioural
// 256 x 32 synchronous-read memory. Inputs change 1 ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_idx;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.IDX_W(8), .LOCK_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_lock    (l_lock),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .l_err     (l_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_idx   (mem_idx),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory with synchronous read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_idx] <= mem_wdata;
            else        mem_rdata    <= mem[mem_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_l;
        logic prev_l;

        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
        mem_rdata = 32'h5A5A5A5A;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | i;
        mem[4] = 32'h00500093;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_f_gnt",    f_gnt, 0);
        check("rst_l_gnt",    l_gnt, 0);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_l_rvalid", l_rvalid, 0);
        check("rst_f_err",    f_err, 0);
        check("rst_l_err",    l_err, 0);
        check("rst_mem_en",   mem_en, 0);
        check("rst_mem_we",   mem_we, 0);
        check("rst_mem_idx",  mem_idx, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_f_rdata",  f_rdata, 0);
        check("rst_l_rdata",  l_rdata, 0);
        step();
        rst = 1'b0;

        // Fetch of 0x10 reads word 4
        f_req = 1'b1; f_addr = 32'h10;
        @(negedge clk);
        check("f1_gnt",    f_gnt, 1);
        check("f1_l_gnt",  l_gnt, 0);
        check("f1_mem_en", mem_en, 1);
        check("f1_mem_we", mem_we, 0);
        check("f1_mem_idx", mem_idx, 4);
        step();
        f_req = 1'b0; f_addr = '0;
        @(negedge clk);
        check("f1_rvalid", f_rvalid, 1);
        check("f1_rdata",  f_rdata, 32'h00500093);
        check("f1_err",    f_err, 0);
        check("f1_l_rvalid", l_rvalid, 0);
        check("f1_idle_en", mem_en, 0);
        step();

        // Round-robin: last owner is FETCH, so the order is L, F, L, F
        f_req = 1'b1; f_addr = 32'hC;
        l_req = 1'b1; l_addr = 32'h8; l_we = 1'b0; l_lock = 1'b0;
        prev_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_l = (i % 2 == 0);
            check("rr_l_gnt", l_gnt, exp_l);
            check("rr_f_gnt", f_gnt, !exp_l);
            if (i > 0) begin
                check("rr_l_rvalid", l_rvalid, prev_l);
                check("rr_f_rvalid", f_rvalid, !prev_l);
                check("rr_rdata", prev_l ? l_rdata : f_rdata,
                      prev_l ? 32'hA5000002 : 32'hA5000003);
            end
            prev_l = exp_l;
            step();
        end
        f_req = 1'b0; l_req = 1'b0;
        @(negedge clk);
        check("rr_last_f_rvalid", f_rvalid, 1);
        check("rr_last_f_rdata",  f_rdata, 32'hA5000003);
        check("rr_last_l_rvalid", l_rvalid, 0);
        step();

        // Lock: 16 loader grants, one forced fetch, then the loader resumes
        f_req = 1'b1; f_addr = 32'hC;
        l_req = 1'b1; l_addr = 32'h8; l_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_l = (i != 16);
            check("lock_l_gnt", l_gnt, exp_l);
            check("lock_f_gnt", f_gnt, !exp_l);
            step();
        end
        f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
        step();

        // Misaligned fetch
        f_req = 1'b1; f_addr = 32'h6;
        @(negedge clk);
        check("mis_f_gnt",  f_gnt, 1);
        check("mis_mem_en", mem_en, 0);
        step();
        // Out-of-range fetch; the previous error response is checked first
        f_addr = 32'h400;
        @(negedge clk);
        check("mis_rvalid", f_rvalid, 1);
        check("mis_err",    f_err, 1);
        check("mis_rdata",  f_rdata, 0);
        check("oor_f_gnt",  f_gnt, 1);
        check("oor_mem_en", mem_en, 0);
        step();
        f_req = 1'b0; f_addr = '0;
        @(negedge clk);
        check("oor_rvalid", f_rvalid, 1);
        check("oor_err",    f_err, 1);
        check("oor_rdata",  f_rdata, 0);
        step();

        // Loader read error
        l_req = 1'b1; l_we = 1'b0; l_addr = 32'h1;
        @(negedge clk);
        check("lerr_gnt",    l_gnt, 1);
        check("lerr_mem_en", mem_en, 0);
        step();
        l_req = 1'b0; l_addr = '0;
        @(negedge clk);
        check("lerr_rvalid", l_rvalid, 1);
        check("lerr_err",    l_err, 1);
        check("lerr_rdata",  l_rdata, 0);
        check("lerr_f_rvalid", f_rvalid, 0);
        step();

        // Loader write, then a fetch of the same word
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_l_gnt",  l_gnt, 1);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_idx", mem_idx, 8);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        f_req = 1'b1; f_addr = 32'h20;
        @(negedge clk);
        check("raw_f_gnt",  f_gnt, 1);
        check("raw_mem_we", mem_we, 0);
        check("raw_mem_idx", mem_idx, 8);
        check("wr_l_rvalid", l_rvalid, 1);
        check("wr_l_rdata",  l_rdata, 0);
        check("wr_l_err",    l_err, 0);
        step();
        f_req = 1'b0; f_addr = '0;
        @(negedge clk);
        check("raw_f_rvalid", f_rvalid, 1);
        check("raw_f_rdata",  f_rdata, 32'hDEADBEEF);
        step();

        // Mid-operation reset: make LOADER the last owner, then reset during a fetch grant
        l_req = 1'b1; l_addr = 32'h8;
        @(negedge clk);
        check("mr_l_gnt", l_gnt, 1);
        step();
        l_req = 1'b0; l_addr = '0;
        f_req = 1'b1; f_addr = 32'h10;
        @(negedge clk);
        check("mr_f_gnt", f_gnt, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_f_rvalid", f_rvalid, 0);
        check("mr_l_rvalid", l_rvalid, 0);
        check("mr_f_gnt_rst", f_gnt, 0);
        check("mr_mem_en",   mem_en, 0);
        check("mr_mem_idx",  mem_idx, 0);
        check("mr_f_rdata",  f_rdata, 0);
        step();
        rst = 1'b0;
        // After reset the last owner is FETCH, so the loader wins the tie
        f_req = 1'b1; f_addr = 32'hC;
        l_req = 1'b1; l_addr = 32'h8;
        @(negedge clk);
        check("mr_tie_l_gnt", l_gnt, 1);
        check("mr_tie_f_gnt", f_gnt, 0);
        step();
        f_req = 1'b0; l_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates the single-port, synchronous-read instruction memory (256 × 32-bit words, 1 KiB) between two requesters: the CPU fetch stage and the program loader/debug port. It owns every memory-enable, write-enable, word-index and write-data signal. It grants at most one access per cycle, using round-robin with a bounded loader lock. It returns read data and error status to the granted requester one cycle later.

## Interface
Parameters:
- IDX_W, 8, word-index width; memory depth is 2^IDX_W words.
- LOCK_MAX, 16, maximum consecutive loader grants under l_lock before one fetch grant is forced.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held with f_addr stable until f_gnt.
- f_addr  in  32  fetch byte address (PC).
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid, one cycle after f_gnt.
- f_rdata  out  32  fetch instruction word; 0 when f_err.
- f_err  out  1  fetch address misaligned or out of range; qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) or read (0).
- l_lock  in  1  loader requests exclusive back-to-back ownership.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader accepted this cycle (combinational).
- l_rvalid  out  1  loader response valid, one cycle after l_gnt; asserted for writes as well as reads.
- l_rdata  out  32  loader read data; 0 for writes and errors.
- l_err  out  1  loader address error; qualified by l_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_idx  out  IDX_W  word index = addr[IDX_W+1:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

## Operation
- Address check, per requester:
  - err = (addr[1:0] != 0) or (addr[31:IDX_W+2] != 0).
  - An errored request is still granted. It produces no memory access (mem_en=0) and the next-cycle response has err=1 and data 0.
- Arbitration, combinational, per cycle:
  - Only one requester active: that requester is granted.
  - Both active: round-robin on last_owner (registered). The requester that was not granted last wins.
- Lock:
  - While the loader holds the last grant and l_lock=1, the loader wins ties.
  - lock_cnt counts consecutive locked loader grants.
  - When lock_cnt == LOCK_MAX and f_req=1, the fetch is granted for one cycle and lock_cnt clears.
  - l_lock=0 or a fetch grant clears lock_cnt.
- FSM, state = last_owner:
  - States: FETCH, LOADER. Reset state is FETCH, so the loader wins the first tie.
  - A grant to a requester moves the state to that requester. No grant holds the state.
- Response pipeline:
  - Registered resp_owner, resp_err and resp_valid capture the granted transaction.
  - The next cycle routes mem_rdata to the owner, or 0 if the transaction was an error or a write.
  - Only the owner's rvalid pulses.
- Memory drive:
  - mem_en = grant and not err.
  - mem_we = loader grant and l_we.
  - mem_idx and mem_wdata come from the granted requester; they are 0 when idle.
- Read-after-write: a fetch granted the cycle after a loader write to the same index returns the new word. The memory itself provides this; the arbiter adds no forwarding.

## Timing
- Reset values: f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, mem_en and mem_we are 0; f_rdata, l_rdata, mem_idx and mem_wdata are 0; last_owner=FETCH; lock_cnt=0.
- Grant latency: 0 cycles (same cycle as the request).
- Response latency: exactly 1 cycle after the grant.
- Throughput: one access per cycle. With both requesters active and no lock, grants alternate every cycle.
- Reset asserted mid-operation: a pending response is discarded and rvalid is 0 from the reset edge onward. A memory write in the reset cycle is not guaranteed.
- Request dropped before grant: no effect and no response.
- A request that is not granted must stay stable; it is serviced no later than 1 cycle after the other requester's grant, or LOCK_MAX+1 cycles under lock.

## Test plan
- After reset, f_req=1 with f_addr=0x10 and memory word 4 = 0x00500093 -> f_gnt=1 the same cycle, mem_idx=4, next cycle f_rvalid=1 and f_rdata=0x00500093.
- f_req and l_req both held for 4 cycles, no lock -> grants in the order L, F, L, F; each rvalid one cycle after its grant.
- l_lock=1 with l_req and f_req held for 20 cycles, LOCK_MAX=16 -> 16 loader grants, then 1 fetch grant, then loader grants resume.
- f_addr=0x6 -> f_gnt=1, mem_en=0, next cycle f_err=1 and f_rdata=0. f_addr=0x400 -> same result.
- Loader writes 0xDEADBEEF to 0x20, fetch of 0x20 the next cycle -> mem_we pulses with mem_idx=8, l_rvalid=1 with l_rdata=0, f_rdata=0xDEADBEEF.
- rst asserted the cycle after a fetch grant -> f_rvalid stays 0, all outputs 0, last_owner=FETCH.
